// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - command codes, FSM states and lane helpers for the load/store sequencer
package mem_access_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWL = 4'd5,
    LWR = 4'd6,
    SB  = 4'd8,
    SH  = 4'd9,
    SW  = 4'd10
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic is_valid_op(input logic [3:0] op);
    case (op)
      LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    case (op)
      LB, LBU, LH, LHU, LW, LWL, LWR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Halves need an even offset and full words a zero offset; LWL/LWR are unaligned by design.
  function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      LH, LHU, SH: return ~lo[0];
      LW, SW:      return (lo == 2'd0);
      default:     return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      LB, LBU, SB: return 4'b0001 << lo;
      LH, LHU, SH: return lo[1] ? 4'b1100 : 4'b0011;
      LWL:         return 4'b1111 >> (2'd3 - lo);
      LWR:         return 4'b1111 << lo;
      default:     return 4'b1111;
    endcase
  endfunction

  // Lane placement follows access width, so byte/half data lands on every lane it could target.
  function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] d);
    case (op)
      LB, LBU, SB: return {4{d[7:0]}};
      LH, LHU, SH: return {2{d[15:0]}};
      default:     return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - extracts, extends or merges a bus word into a load result
module load_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] readdata,
  input  logic [31:0] rt_old,
  output logic [31:0] load_result
);

  logic [31:0] byte_word;
  logic [15:0] half;
  logic [4:0]  lsh;
  logic [4:0]  rsh;
  logic [5:0]  keep_sh;

  // Select the addressed lane(s) and apply sign/zero extension or the LWL/LWR merge.
  always_comb begin
    byte_word   = readdata >> {offset, 3'b000};
    half        = offset[1] ? readdata[31:16] : readdata[15:0];
    lsh         = {2'd3 - offset, 3'b000};
    rsh         = {offset, 3'b000};
    keep_sh     = {1'b0, offset, 3'b000} + 6'd8;
    load_result = readdata;
    case (op)
      LB:  load_result = {{24{byte_word[7]}}, byte_word[7:0]};
      LBU: load_result = {24'd0, byte_word[7:0]};
      LH:  load_result = {{16{half[15]}}, half};
      LHU: load_result = {16'd0, half};
      LWL: load_result = (readdata << lsh) | (rt_old & (32'hFFFF_FFFF >> keep_sh));
      LWR: load_result = (readdata >> rsh) | (rt_old & ~(32'hFFFF_FFFF >> rsh));
      default: load_result = readdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - sequences one load/store command into a single word-aligned bus transaction
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rt_old,
  output logic              busy,
  output logic              done,
  output logic              addr_error,
  output logic [DATA_W-1:0] load_result,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata
);

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [DATA_W-1:0] rt_old_q, rt_old_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              addr_error_q, addr_error_d;
  logic [DATA_W-1:0] load_result_q, load_result_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [3:0]        byteenable_q, byteenable_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic [DATA_W-1:0] align_result;

  load_align u_load_align (
    .op          (op_q),
    .offset      (off_q),
    .readdata    (readdata),
    .rt_old      (rt_old_q),
    .load_result (align_result)
  );

  // Next-state and next-output logic; a misaligned command spends one check cycle in RESP
  // without touching the bus so that its done pulse lands two cycles after start.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    off_d         = off_q;
    rt_old_d      = rt_old_q;
    err_d         = err_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    addr_error_d  = 1'b0;
    load_result_d = load_result_q;
    address_d     = address_q;
    byteenable_d  = byteenable_q;
    read_d        = read_q;
    write_d       = write_q;
    writedata_d   = writedata_q;
    case (state_q)
      IDLE: begin
        if (start && is_valid_op(op)) begin
          op_d     = op;
          off_d    = addr[1:0];
          rt_old_d = rt_old;
          busy_d   = 1'b1;
          if (!is_aligned(op, addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d        = 1'b0;
            state_d      = ISSUE;
            address_d    = {addr[ADDR_W-1:2], 2'b00};
            byteenable_d = byte_enable(op, addr[1:0]);
            writedata_d  = store_lanes(op, store_data);
            read_d       = is_load(op);
            write_d      = ~is_load(op);
          end
        end
      end
      ISSUE: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (is_load(op_q)) begin
            state_d = RESP;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = DONE;
        done_d  = 1'b1;
        if (err_q) begin
          addr_error_d = 1'b1;
        end else begin
          load_result_d = align_result;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any bus request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      op_q          <= 4'd0;
      off_q         <= 2'd0;
      rt_old_q      <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      addr_error_q  <= 1'b0;
      load_result_q <= '0;
      address_q     <= '0;
      byteenable_q  <= 4'd0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      writedata_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      off_q         <= off_d;
      rt_old_q      <= rt_old_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      addr_error_q  <= addr_error_d;
      load_result_q <= load_result_d;
      address_q     <= address_d;
      byteenable_q  <= byteenable_d;
      read_q        <= read_d;
      write_q       <= write_d;
      writedata_q   <= writedata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign addr_error  = addr_error_q;
  assign load_result = load_result_q;
  assign address     = address_q;
  assign byteenable  = byteenable_q;
  assign read        = read_q;
  assign write       = write_q;
  assign writedata   = writedata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] rt_old;
  logic        busy;
  logic        done;
  logic        addr_error;
  logic [31:0] load_result;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .addr        (addr),
    .store_data  (store_data),
    .rt_old      (rt_old),
    .busy        (busy),
    .done        (done),
    .addr_error  (addr_error),
    .load_result (load_result),
    .address     (address),
    .byteenable  (byteenable),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_size(input logic [3:0] t_op);
    if (t_op == LB || t_op == LBU || t_op == SB) return 1;
    if (t_op == LH || t_op == LHU || t_op == SH) return 2;
    return 4;
  endfunction

  function automatic bit m_is_load(input logic [3:0] t_op);
    return t_op < 4'd8;
  endfunction

  function automatic bit m_err(input logic [3:0] t_op, input logic [1:0] o);
    if (t_op == LWL || t_op == LWR) return 1'b0;
    return (int'(o) % m_size(t_op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] t_op, input logic [1:0] o);
    logic [3:0] be;
    int oi;
    oi = int'(o);
    for (int k = 0; k < 4; k++) begin
      if (t_op == LWL)      be[k] = (k <= oi);
      else if (t_op == LWR) be[k] = (k >= oi);
      else                  be[k] = (k >= oi) && (k < oi + m_size(t_op));
    end
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input logic [3:0] t_op, input logic [31:0] sd);
    logic [31:0] w;
    int sz;
    sz = m_size(t_op);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = sd[8*(k % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_res(input logic [3:0] t_op, input logic [1:0] o,
                                        input logic [31:0] rd, input logic [31:0] rto);
    logic [7:0]  rb [4];
    logic [7:0]  res [4];
    logic [15:0] h;
    int oi;
    oi = int'(o);
    for (int k = 0; k < 4; k++) begin
      rb[k]  = rd[8*k +: 8];
      res[k] = rto[8*k +: 8];
    end
    case (t_op)
      LB:  return {{24{rb[oi][7]}}, rb[oi]};
      LBU: return {24'd0, rb[oi]};
      LH: begin h = {rb[oi+1], rb[oi]}; return {{16{h[15]}}, h}; end
      LHU: begin h = {rb[oi+1], rb[oi]}; return {16'd0, h}; end
      LWL: for (int i = 0; i <= oi; i++) res[3-oi+i] = rb[i];
      LWR: for (int i = 0; i <= 3 - oi; i++) res[i] = rb[oi+i];
      default: return rd;
    endcase
    return {res[3], res[2], res[1], res[0]};
  endfunction

  // ---------------- per-cycle expectations ----------------
  logic        chk_en = 1'b0;
  logic        e_busy, e_done, e_err, e_read, e_write;
  logic [31:0] e_addr, e_wd, e_res;
  logic [3:0]  e_be;

  // Compare every output against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("addr_error", 32'(addr_error), 32'(e_err));
      chk("read", 32'(read), 32'(e_read));
      chk("write", 32'(write), 32'(e_write));
      chk("address", address, e_addr);
      chk("byteenable", 32'(byteenable), 32'(e_be));
      chk("writedata", writedata, e_wd);
      chk("load_result", load_result, e_res);
    end
  end

  task automatic set_idle_exp();
    e_busy = 0; e_done = 0; e_err = 0; e_read = 0; e_write = 0;
  endtask

  // Called #1 after a posedge. Drives one command and steps expectations through its timeline.
  task automatic run(input logic [3:0] t_op, input logic [31:0] t_addr, input logic [31:0] t_sd,
                     input logic [31:0] t_rto, input logic [31:0] t_rd, input int t_w,
                     input bit hold_start);
    bit ld, er;
    int d;
    ld = m_is_load(t_op);
    er = m_err(t_op, t_addr[1:0]);
    d  = er ? 2 : (ld ? 3 + t_w : 2 + t_w);
    op = t_op; addr = t_addr; store_data = t_sd; rt_old = t_rto; readdata = t_rd;
    waitrequest = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= d + 1; c++) begin
      @(posedge clk); #1;
      start = hold_start && (c <= d);
      waitrequest = !er && (c <= t_w);
      e_busy  = (c <= d);
      e_done  = (c == d);
      e_err   = er && (c == d);
      e_read  = ld && !er && (c <= t_w + 1);
      e_write = !ld && !er && (c <= t_w + 1);
      if (!er) begin
        e_addr = {t_addr[31:2], 2'b00};
        e_be   = m_be(t_op, t_addr[1:0]);
        e_wd   = m_wd(t_op, t_sd);
      end
      if (c == d && ld && !er) e_res = m_res(t_op, t_addr[1:0], t_rd, t_rto);
    end
    waitrequest = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; op = 0; addr = 0; store_data = 0; rt_old = 0;
    waitrequest = 0; readdata = 0;
    set_idle_exp();
    e_addr = 0; e_be = 0; e_wd = 0; e_res = 0;

    // model pinned against hand-computed values
    chk("mdl_lwl", m_res(LWL, 2'd1, 32'h44332211, 32'hAABBCCDD), 32'h2211CCDD);
    chk("mdl_lwr", m_res(LWR, 2'd2, 32'h44332211, 32'hAABBCCDD), 32'hAABB4433);
    chk("mdl_lb", m_res(LB, 2'd3, 32'h80112233, 32'h0), 32'hFFFFFF80);
    chk("mdl_be_sh", 32'(m_be(SH, 2'd2)), 32'h0000000C);
    chk("mdl_wd_sh", m_wd(SH, 32'h1234ABCD), 32'hABCDABCD);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_result", load_result, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    run(LW, 32'h00000010, 32'h0, 32'h0, 32'h8899AABB, 0, 0);
    chk("lw_lit", load_result, 32'h8899AABB);
    run(LB, 32'h00000013, 32'h0, 32'h0, 32'h80112233, 0, 0);
    chk("lb_lit", load_result, 32'hFFFFFF80);
    run(LBU, 32'h00000013, 32'h0, 32'h0, 32'h80112233, 0, 0);
    chk("lbu_lit", load_result, 32'h00000080);
    run(SH, 32'h00000022, 32'h1234ABCD, 32'h0, 32'h0, 3, 1);
    chk("sh_keeps_result", load_result, 32'h00000080);
    run(LWL, 32'h00000041, 32'h0, 32'hAABBCCDD, 32'h44332211, 0, 0);
    chk("lwl_lit", load_result, 32'h2211CCDD);
    run(LWR, 32'h00000042, 32'h0, 32'hAABBCCDD, 32'h44332211, 1, 0);
    chk("lwr_lit", load_result, 32'hAABB4433);
    run(LW, 32'h00000006, 32'h0, 32'h0, 32'h12345678, 0, 0);
    chk("misaligned_keeps_result", load_result, 32'hAABB4433);
    run(SB, 32'h00000101, 32'h000000C3, 32'h0, 32'h0, 1, 0);
    run(LHU, 32'h00000202, 32'h0, 32'h0, 32'hF00D8001, 2, 0);
    run(LH, 32'h00000200, 32'h0, 32'h0, 32'h1234F00D, 0, 0);
    run(SW, 32'h0000000C, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0);
    run(SH, 32'h00000003, 32'h11112222, 32'h0, 32'h0, 0, 0);
    run(LWR, 32'h00000040, 32'h0, 32'hAABBCCDD, 32'h44332211, 0, 0);
    run(LWL, 32'h00000043, 32'h0, 32'hAABBCCDD, 32'h44332211, 0, 0);

    // an invalid op is ignored; the per-cycle compare expects idle throughout
    op = 4'd7; addr = 32'h10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("invalid_op_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // reset while a read is stalled in ISSUE
    chk_en = 1'b0;
    op = LW; addr = 32'h00000080; readdata = 32'h55; waitrequest = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("pre_reset_read", 32'(read), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_read", 32'(read), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_address", address, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_no_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0; waitrequest = 1'b0;
    set_idle_exp();
    e_addr = 0; e_be = 0; e_wd = 0; e_res = 0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    run(LW, 32'h00000010, 32'h0, 32'h0, 32'hCAFEF00D, 1, 0);
    chk("post_reset_lw", load_result, 32'hCAFEF00D);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side load/store sequencer between the MIPS datapath and the data-memory bus (address/byteenable/read/write/writedata/waitrequest/readdata).
- Turns one load or store command into a single word-aligned bus transaction: byte-enable generation, store-lane replication, waitrequest stalling, read-data capture.
- Returns an extracted, sign/zero-extended or merged load result with a one-cycle done pulse.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, bus word width; fixed at 32, other values unsupported

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- op  in  4  mem_op_t command (package)
- addr  in  32  effective byte address
- store_data  in  32  rt value for stores
- rt_old  in  32  current rt value, merged by LWL/LWR
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- addr_error  out  1  valid with done; misaligned access, no bus cycle issued
- load_result  out  32  valid with done for loads; held until next done
- address  out  32  word-aligned bus address ({addr[31:2],2'b00})
- byteenable  out  4  lane k = byte (address+k), data bits [8k+7:8k]
- read  out  1  bus read request
- write  out  1  bus write request
- writedata  out  32  lane-placed store data
- waitrequest  in  1  bus stall; request is held while high
- readdata  in  32  valid the cycle after an accepted read

Behaviour:
- Reset (async): state=IDLE. busy, done, addr_error, read, write = 0. address, byteenable, writedata, load_result = 0.
- States: IDLE, ISSUE, RESP, DONE. All outputs are registered.
- IDLE:
  - start=1 with a valid op latches op, addr, store_data and rt_old.
  - Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) → DONE with addr_error=1; read and write never assert.
  - Aligned access → ISSUE with address, byteenable and writedata registered.
  - start with an invalid op, or start outside IDLE, is ignored.
- ISSUE:
  - read (loads) or write (stores) is high. address, byteenable and writedata stay stable.
  - Edge with waitrequest=0 accepts the request: read or write drops. Stores → DONE; loads → RESP.
  - waitrequest=1: stay in ISSUE with everything held, no limit on stall length.
- RESP: capture readdata through load_align into load_result → DONE.
- DONE: done=1 for exactly one cycle → IDLE; addr_error cleared on exit.
- Latency with no stalls: store start→done = 2 cycles; load = 3 cycles. Each waitrequest cycle adds 1.
- Byte enables, with o=addr[1:0]:
  - LB/LBU/SB: one-hot lane o.
  - LH/LHU/SH: 0011 (o=0) or 1100 (o=2).
  - LW/SW: 1111.
  - LWL: lanes 0..o.
  - LWR: lanes o..3.
- Store data: SB replicates the byte ×4, SH replicates the half ×2, SW passes through.
- Load extraction:
  - LB/LBU: lane o, sign/zero-extended.
  - LH/LHU: half o/2, sign/zero-extended.
  - LW: whole word.
  - LWL: result = (readdata << 8*(3-o)) | (rt_old & (32'hFFFFFFFF >> 8*(o+1))); o=3 gives the full word.
  - LWR: result = (readdata >> 8*o) | (rt_old & ~(32'hFFFFFFFF >> 8*o)); o=0 gives the full word.
- Stores leave load_result unchanged.
- Reset asserted mid-transaction drops read/write immediately; no done is produced.

Decomposition:
- Package mem_access_pkg:
  - mem_op_t: LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6, SB=8, SH=9, SW=10; other codes invalid.
  - state_t.
  - Helpers is_load(op) and is_aligned(op, addr[1:0]).
- Sub-module load_align: purely combinational; inputs op, offset, readdata, rt_old; output load_result. Tested standalone.

Test Plan:
- LW addr=0x00000010, waitrequest=0, readdata=0x8899AABB → address=0x10, byteenable=1111, read high for 1 cycle; done at cycle 3; load_result=0x8899AABB.
- LB vs LBU addr=0x13 with readdata=0x80112233 → byteenable=1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH addr=0x22, store_data=0x1234ABCD, waitrequest high for 3 cycles → write held 4 cycles with address=0x20, byteenable=1100, writedata=0xABCDABCD throughout; done 5 cycles after start.
- LWL addr=0x41, readdata=0x44332211, rt_old=0xAABBCCDD → byteenable=0011, load_result=0x2211CCDD. LWR addr=0x42, same data → byteenable=1100, load_result=0xAABB4433.
- LW addr=0x06 → no read asserted; done with addr_error=1 two cycles after start; load_result unchanged.
- Reset asserted during ISSUE with waitrequest=1 → read=0 and busy=0 immediately; no done pulse; next start is accepted normally.
